// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the RSA-decryption ASIP.
// Each cycle it decides whether the PC advances, holds or loads a redirect target.
// Optional feature macro: FETCH_CTRL_PERF_EN enables the stall/redirect performance counters.
module fetch_ctrl #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] boot_pc,
   input  logic             branch_req,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             hazard_stall,
   input  logic             mexp_busy,
   input  logic             halt_instr,
   output logic             pc_en,
   output logic             pc_selector,
   output logic [WIDTH-1:0] jmp_pc,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             halted,
   output logic [2:0]       fsm_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam int unsigned FC_W        = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
   localparam logic        MULTI_FLUSH = (FLUSH_DEPTH > 1);
   localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_STALL = 3'd2,
      S_FLUSH = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [FC_W-1:0]   fcnt;
   logic [FC_W-1:0]   fcnt_nxt;
   logic              redirect;
   logic [WIDTH-1:0]  redir_addr;

   // State and flush-counter register; reset abandons any redirect or stall in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Next-state and fetch-control decode; everything forced low while reset is held
   always_comb begin
      state_nxt   = state;
      fcnt_nxt    = fcnt;
      pc_en       = 1'b0;
      pc_selector = 1'b0;
      jmp_pc      = '0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      redirect    = 1'b0;
      redir_addr  = '0;

      if (reset) begin
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  redirect   = 1'b1;
                  redir_addr = boot_pc;
                  state_nxt  = S_RUN;
               end
            end
            S_RUN, S_STALL: begin
               // A branch comes from an older instruction, so it beats halt and stalls
               if (branch_req) begin
                  redirect   = 1'b1;
                  redir_addr = branch_target;
                  if (MULTI_FLUSH) begin
                     state_nxt = S_FLUSH;
                     fcnt_nxt  = FC_RELOAD;
                  end else begin
                     state_nxt = S_RUN;
                  end
               end else if (halt_instr) begin
                  flush_ifid = 1'b1;
                  state_nxt  = S_HALT;
               end else if (hazard_stall || mexp_busy) begin
                  flush_idex = hazard_stall;
                  state_nxt  = S_STALL;
               end else begin
                  pc_en     = 1'b1;
                  state_nxt = S_RUN;
               end
            end
            S_FLUSH: begin
               // Stalls are ignored here: the instructions being squashed are dead
               if (branch_req) begin
                  redirect   = 1'b1;
                  redir_addr = branch_target;
                  if (MULTI_FLUSH) begin
                     state_nxt = S_FLUSH;
                     fcnt_nxt  = FC_RELOAD;
                  end else begin
                     state_nxt = S_RUN;
                  end
               end else begin
                  pc_en      = 1'b1;
                  flush_ifid = 1'b1;
                  if (fcnt <= FC_W'(1)) begin
                     fcnt_nxt  = '0;
                     state_nxt = S_RUN;
                  end else begin
                     fcnt_nxt  = fcnt - FC_W'(1);
                  end
               end
            end
            default: begin
               state_nxt = S_IDLE;
               fcnt_nxt  = '0;
            end
         endcase

         if (redirect) begin
            pc_en       = 1'b1;
            pc_selector = 1'b1;
            jmp_pc      = redir_addr;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
         end
      end
   end

   assign halted    = (state == S_HALT);
   assign fsm_state = state;

`ifdef FETCH_CTRL_PERF_EN
   logic stall_inc;
   logic redir_inc;

   assign stall_inc = reset && !pc_en && ((state == S_RUN) || (state == S_STALL));
   assign redir_inc = redirect;

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redir_inc && (redirect_cnt != {CNT_W{1'b1}}))
            redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt    = '0;
   assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (WIDTH=32, FLUSH_DEPTH=2, CNT_W=16).
// Inputs change on the falling edge; combinational outputs are sampled 1ns later.
module tb_fetch_ctrl;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 16;
`ifdef FETCH_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] boot_pc;
   logic             branch_req;
   logic [WIDTH-1:0] branch_target;
   logic             hazard_stall;
   logic             mexp_busy;
   logic             halt_instr;
   logic             pc_en;
   logic             pc_selector;
   logic [WIDTH-1:0] jmp_pc;
   logic             flush_ifid;
   logic             flush_idex;
   logic             halted;
   logic [2:0]       fsm_state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   int unsigned n_checks;
   int unsigned n_errors;

   fetch_ctrl #(.WIDTH(WIDTH), .FLUSH_DEPTH(2), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .boot_pc       (boot_pc),
      .branch_req    (branch_req),
      .branch_target (branch_target),
      .hazard_stall  (hazard_stall),
      .mexp_busy     (mexp_busy),
      .halt_instr    (halt_instr),
      .pc_en         (pc_en),
      .pc_selector   (pc_selector),
      .jmp_pc        (jmp_pc),
      .flush_ifid    (flush_ifid),
      .flush_idex    (flush_idex),
      .halted        (halted),
      .fsm_state     (fsm_state),
      .stall_cnt     (stall_cnt),
      .redirect_cnt  (redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Check the full fetch-control output vector in one go
   task automatic check_ctl(input string tag, input logic en, input logic sel,
                            input logic [WIDTH-1:0] pc, input logic fi, input logic fx,
                            input logic [2:0] st);
      check({tag, ".pc_en"},       64'(pc_en),       64'(en));
      check({tag, ".pc_selector"}, 64'(pc_selector), 64'(sel));
      check({tag, ".jmp_pc"},      64'(jmp_pc),      64'(pc));
      check({tag, ".flush_ifid"},  64'(flush_ifid),  64'(fi));
      check({tag, ".flush_idex"},  64'(flush_idex),  64'(fx));
      check({tag, ".fsm_state"},   64'(fsm_state),   64'(st));
      check({tag, ".halted"},      64'(halted),      64'(st == 3'd4));
   endtask

   task automatic check_cnt(input string tag, input int unsigned st_exp, input int unsigned rd_exp);
      check({tag, ".stall_cnt"},    64'(stall_cnt),    PERF ? 64'(st_exp) : 64'd0);
      check({tag, ".redirect_cnt"}, 64'(redirect_cnt), PERF ? 64'(rd_exp) : 64'd0);
   endtask

   task automatic clear_inputs();
      start = 1'b0; boot_pc = '0; branch_req = 1'b0; branch_target = '0;
      hazard_stall = 1'b0; mexp_busy = 1'b0; halt_instr = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_inputs();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check_ctl("in_reset", 0, 0, 32'h0, 0, 0, 3'd0);
      check_cnt("in_reset", 0, 0);

      // Idle after release: nothing happens without start
      @(negedge clk); reset = 1'b1;
      #1 check_ctl("idle", 0, 0, 32'h0, 0, 0, 3'd0);

      // Boot from IDLE
      @(negedge clk); start = 1'b1; boot_pc = 32'h0000_0100;
      #1 check_ctl("boot", 1, 1, 32'h100, 1, 1, 3'd0);
      @(negedge clk); clear_inputs();
      #1 check_ctl("run0", 1, 0, 32'h0, 0, 0, 3'd1);

      // Branch redirect, FLUSH_DEPTH=2
      @(negedge clk); branch_req = 1'b1; branch_target = 32'h1000;
      #1 check_ctl("br_c0", 1, 1, 32'h1000, 1, 1, 3'd1);
      @(negedge clk); clear_inputs();
      #1 check_ctl("br_c1", 1, 0, 32'h0, 1, 0, 3'd3);
      @(negedge clk);
      #1 check_ctl("br_c2", 1, 0, 32'h0, 0, 0, 3'd1);
      check_cnt("after_br", 0, 2);

      // Modexp busy for 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); mexp_busy = 1'b1;
         #1 check_ctl($sformatf("mexp%0d", i), 0, 0, 32'h0, 0, 0, (i == 0) ? 3'd1 : 3'd2);
      end
      @(negedge clk); mexp_busy = 1'b0;
      #1 check_ctl("mexp_resume", 1, 0, 32'h0, 0, 0, 3'd2);
      check_cnt("after_mexp", 5, 2);
      @(negedge clk);
      #1 check_ctl("mexp_run", 1, 0, 32'h0, 0, 0, 3'd1);

      // Load-use stall, then a branch overrides it
      @(negedge clk); hazard_stall = 1'b1;
      #1 check_ctl("haz_run", 0, 0, 32'h0, 0, 1, 3'd1);
      @(negedge clk); branch_req = 1'b1; branch_target = 32'h2000;
      #1 check_ctl("haz_br", 1, 1, 32'h2000, 1, 1, 3'd2);
      @(negedge clk); branch_req = 1'b0;
      // Stall is ignored while flushing
      #1 check_ctl("flush_haz", 1, 0, 32'h0, 1, 0, 3'd3);
      @(negedge clk); hazard_stall = 1'b0;
      #1 check_ctl("haz_done", 1, 0, 32'h0, 0, 0, 3'd1);

      // Branch re-issued during FLUSH reloads the flush counter
      @(negedge clk); branch_req = 1'b1; branch_target = 32'h3000;
      #1 check_ctl("fl_br0", 1, 1, 32'h3000, 1, 1, 3'd1);
      @(negedge clk); branch_target = 32'h3400;
      #1 check_ctl("fl_br1", 1, 1, 32'h3400, 1, 1, 3'd3);
      @(negedge clk); clear_inputs();
      #1 check_ctl("fl_br2", 1, 0, 32'h0, 1, 0, 3'd3);
      @(negedge clk);
      #1 check_ctl("fl_br3", 1, 0, 32'h0, 0, 0, 3'd1);
      check_cnt("after_flush", 6, 5);

      // Halt, branch ignored in HALT, restart at 0
      @(negedge clk); halt_instr = 1'b1;
      #1 check_ctl("halt_c0", 0, 0, 32'h0, 1, 0, 3'd1);
      @(negedge clk); halt_instr = 1'b0; branch_req = 1'b1; branch_target = 32'h4000;
      hazard_stall = 1'b1;
      #1 check_ctl("halt_ign", 0, 0, 32'h0, 0, 0, 3'd4);
      @(negedge clk); clear_inputs(); start = 1'b1; boot_pc = 32'h0;
      #1 check_ctl("restart", 1, 1, 32'h0, 1, 1, 3'd4);
      @(negedge clk); clear_inputs();
      #1 check_ctl("restart_run", 1, 0, 32'h0, 0, 0, 3'd1);
      check_cnt("after_halt", 7, 6);

      // start is ignored outside IDLE/HALT
      @(negedge clk); start = 1'b1; boot_pc = 32'h500;
      #1 check_ctl("start_ign", 1, 0, 32'h0, 0, 0, 3'd1);

      // Async reset in the middle of a stall
      @(negedge clk); clear_inputs(); hazard_stall = 1'b1;
      @(negedge clk);
      #1 check_ctl("pre_rst", 0, 0, 32'h0, 0, 1, 3'd2);
      #2 reset = 1'b0;
      #1 check_ctl("async_rst", 0, 0, 32'h0, 0, 0, 3'd0);
      check_cnt("async_rst", 0, 0);
      @(negedge clk); reset = 1'b1; hazard_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check_ctl($sformatf("post_rst%0d", i), 0, 0, 32'h0, 0, 0, 3'd0);
      end
      @(negedge clk); start = 1'b1; boot_pc = 32'h0000_0200;
      #1 check_ctl("reboot", 1, 1, 32'h200, 1, 1, 3'd0);
      @(negedge clk); clear_inputs();
      #1 check_ctl("reboot_run", 1, 0, 32'h0, 0, 0, 3'd1);
      check_cnt("reboot", 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
